// File: rtl/cdb_pkg.sv
// Shared CDB definitions: tag/data widths, the "no producer" tag and
// small index helpers used by the arbiter (up to 8 requesters).
package cdb_pkg;
  localparam int LABEL_W = 5;
  localparam int DATA_W  = 32;
  localparam int MAX_N   = 8;
  localparam logic [LABEL_W-1:0] NO_LABEL = '0;

  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
    return MAX_N'(1) << idx;
  endfunction

  function automatic logic [2:0] incMod(input logic [2:0] v, input int n);
    return (int'(v) >= n - 1) ? 3'd0 : v + 3'd1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate elig so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);
  logic [N-1:0]  rot;
  logic [PW-1:0] enc;
  logic [PW:0]   src;
  logic [PW:0]   sum;

  always_comb begin
    rot = '0;
    src = '0;
    for (int i = 0; i < N; i++) begin
      src = (PW+1)'(i) + {1'b0, ptr};
      if (src >= (PW+1)'(N)) src = src - (PW+1)'(N);
      rot[i] = elig[src[PW-1:0]];
    end
  end

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) enc = PW'(i);
  end

  assign found = |rot;

  always_comb begin
    sum = {1'b0, enc} + {1'b0, ptr};
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
  end

  assign idx = sum[PW-1:0];
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one registered winner per cycle onto BCEN/BClabel/
// BCdata with a one-cycle ack back to the winning functional unit.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N       = 4,
  parameter int LABEL_W = cdb_pkg::LABEL_W,
  parameter int DATA_W  = cdb_pkg::DATA_W,
  localparam int PW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [N-1:0]         req,
  input  logic [N*LABEL_W-1:0] reqLabel,
  input  logic [N*DATA_W-1:0]  reqData,
  input  logic                 flush,
  output logic [N-1:0]         ack,
  output logic                 BCEN,
  output logic [LABEL_W-1:0]   BClabel,
  output logic [DATA_W-1:0]    BCdata,
  output logic [7:0]           busyCnt
);
  logic [PW-1:0]      ptr;
  logic [N-1:0]       elig;
  logic               found;
  logic [PW-1:0]      idx;
  logic [LABEL_W-1:0] winLabel;
  logic [DATA_W-1:0]  winData;
  logic               contended;

  // The unit acked this cycle is still dropping req; keep it out of the race.
  assign elig      = req & ~ack;
  assign contended = ($countones(elig) >= 2);

  rr_pick #(.N(N)) uPick (
    .elig  (elig),
    .ptr   (ptr),
    .found (found),
    .idx   (idx)
  );

  assign winLabel = reqLabel[idx*LABEL_W +: LABEL_W];
  assign winData  = reqData[idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ack     <= '0;
      BCEN    <= 1'b0;
      BClabel <= '0;
      BCdata  <= '0;
      busyCnt <= '0;
      ptr     <= '0;
    end else begin
      if (!flush && contended && busyCnt != 8'hFF)
        busyCnt <= busyCnt + 8'd1;
      if (flush || !found) begin
        ack  <= '0;
        BCEN <= 1'b0;
      end else begin
        // Tag 0 retires the requester without a broadcast.
        ack     <= N'(onehot(3'(idx)));
        BCEN    <= (winLabel != LABEL_W'(NO_LABEL));
        BClabel <= winLabel;
        BCdata  <= winData;
        ptr     <= PW'(incMod(3'(idx), N));
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter: expected bus/ack values are queued as
// stimulus is driven and compared one cycle later.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int LW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          flush = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*LW-1:0] reqLabel = '0;
  logic [N*DW-1:0] reqData = '0;
  logic [N-1:0]  ack;
  logic          BCEN;
  logic [LW-1:0] BClabel;
  logic [DW-1:0] BCdata;
  logic [7:0]    busyCnt;

  cdb_arbiter #(.N(N), .LABEL_W(LW), .DATA_W(DW)) dut (
    .clk      (clk),
    .RST      (RST),
    .req      (req),
    .reqLabel (reqLabel),
    .reqData  (reqData),
    .flush    (flush),
    .ack      (ack),
    .BCEN     (BCEN),
    .BClabel  (BClabel),
    .BCdata   (BCdata),
    .busyCnt  (busyCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  ack;
    logic          bcen;
    logic [LW-1:0] lbl;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setUnit(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
    reqLabel[i*LW +: LW] = l;
    reqData[i*DW +: DW]  = d;
  endtask

  task automatic doReset;
    RST = 1'b1; req = '0; flush = 1'b0;
    tick;
    RST = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    doReset;
    setUnit(0, 5'd7, 32'd99);
    req = 4'b0001;
    sb.push_back('{4'b0001, 1'b1, 5'd7, 32'd99});
    tick;
    e = sb.pop_front(); vectors++;
    if ({ack, BCEN, BClabel, BCdata} !== e) begin
      miscompares++;
      $display("FAIL reset_pre: got ack=%b BCEN=%b label=%0d data=%0d, want ack=%b BCEN=%b label=%0d data=%0d",
               ack, BCEN, BClabel, BCdata, e.ack, e.bcen, e.lbl, e.dat);
    end
    #2 RST = 1'b1;
    #1; vectors++;
    if ({ack, BCEN, BClabel, BCdata, busyCnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got ack=%b BCEN=%b label=%0d data=%0d busy=%0d, want all zero",
               ack, BCEN, BClabel, BCdata, busyCnt);
    end
    req = '0;
    tick;
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sb.push_back('{4'b0000, 1'b0, 5'd0, 32'd0});
      tick;
      e = sb.pop_front(); vectors++;
      if ({ack, BCEN, BClabel, BCdata} !== e) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got ack=%b BCEN=%b label=%0d data=%0d, want ack=%b BCEN=%b label=%0d data=%0d",
                 c, ack, BCEN, BClabel, BCdata, e.ack, e.bcen, e.lbl, e.dat);
      end
    end
  endtask

  task automatic test_single;
    exp_t e;
    logic [N-1:0] rq[2] = '{4'b0001, 4'b0000};
    exp_t ex[2] = '{'{4'b0001, 1'b1, 5'd4, 32'd25}, '{4'b0000, 1'b0, 5'd4, 32'd25}};
    doReset;
    setUnit(0, 5'd4, 32'd25);
    for (int c = 0; c < 2; c++) begin
      req = rq[c];
      sb.push_back(ex[c]);
      tick;
      e = sb.pop_front(); vectors++;
      if ({ack, BCEN, BClabel, BCdata} !== e) begin
        miscompares++;
        $display("FAIL single[%0d]: got ack=%b BCEN=%b label=%0d data=%0d, want ack=%b BCEN=%b label=%0d data=%0d",
                 c, ack, BCEN, BClabel, BCdata, e.ack, e.bcen, e.lbl, e.dat);
      end
    end
  endtask

  task automatic test_contention;
    exp_t e;
    logic [N-1:0] rq[8] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0011, 4'b0011, 4'b0010, 4'b0000};
    logic fl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t ex[8] = '{'{4'b0001, 1'b1, 5'd1, 32'd100}, '{4'b0010, 1'b1, 5'd2, 32'd101},
                    '{4'b0100, 1'b1, 5'd3, 32'd102}, '{4'b1000, 1'b1, 5'd4, 32'd103},
                    '{4'b0000, 1'b0, 5'd4, 32'd103}, '{4'b0001, 1'b1, 5'd1, 32'd100},
                    '{4'b0010, 1'b1, 5'd2, 32'd101}, '{4'b0000, 1'b0, 5'd2, 32'd101}};
    doReset;
    for (int i = 0; i < N; i++) setUnit(i, LW'(i + 1), DW'(100 + i));
    for (int c = 0; c < 8; c++) begin
      req = rq[c]; flush = fl[c];
      sb.push_back(ex[c]);
      tick;
      e = sb.pop_front(); vectors++;
      if ({ack, BCEN, BClabel, BCdata} !== e) begin
        miscompares++;
        $display("FAIL contention[%0d]: got ack=%b BCEN=%b label=%0d data=%0d, want ack=%b BCEN=%b label=%0d data=%0d",
                 c, ack, BCEN, BClabel, BCdata, e.ack, e.bcen, e.lbl, e.dat);
      end
      if (c == 3 || c == 4 || c == 7) begin
        vectors++;
        if (busyCnt !== ((c == 7) ? 8'd4 : 8'd3)) begin
          miscompares++;
          $display("FAIL contention_busy[%0d]: got busyCnt=%0d, want %0d", c, busyCnt, (c == 7) ? 4 : 3);
        end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_rotation;
    exp_t e;
    logic [N-1:0] rq[5] = '{4'b0100, 4'b0000, 4'b0101, 4'b0000, 4'b0101};
    exp_t ex[5] = '{'{4'b0100, 1'b1, 5'd11, 32'd12}, '{4'b0000, 1'b0, 5'd11, 32'd12},
                    '{4'b0001, 1'b1, 5'd9, 32'd10},  '{4'b0000, 1'b0, 5'd9, 32'd10},
                    '{4'b0100, 1'b1, 5'd11, 32'd12}};
    doReset;
    setUnit(0, 5'd9, 32'd10);
    setUnit(2, 5'd11, 32'd12);
    for (int c = 0; c < 5; c++) begin
      req = rq[c];
      sb.push_back(ex[c]);
      tick;
      e = sb.pop_front(); vectors++;
      if ({ack, BCEN, BClabel, BCdata} !== e) begin
        miscompares++;
        $display("FAIL rotation[%0d]: got ack=%b BCEN=%b label=%0d data=%0d, want ack=%b BCEN=%b label=%0d data=%0d",
                 c, ack, BCEN, BClabel, BCdata, e.ack, e.bcen, e.lbl, e.dat);
      end
    end
  endtask

  task automatic test_tag0_flush;
    exp_t e;
    logic [N-1:0] rq[3] = '{4'b0010, 4'b0001, 4'b0001};
    logic fl[3] = '{1'b0, 1'b1, 1'b0};
    exp_t ex[3] = '{'{4'b0010, 1'b0, 5'd0, 32'd55}, '{4'b0000, 1'b0, 5'd0, 32'd55},
                    '{4'b0001, 1'b1, 5'd5, 32'd66}};
    doReset;
    setUnit(1, 5'd0, 32'd55);
    setUnit(0, 5'd5, 32'd66);
    for (int c = 0; c < 3; c++) begin
      req = rq[c]; flush = fl[c];
      sb.push_back(ex[c]);
      tick;
      e = sb.pop_front(); vectors++;
      if ({ack, BCEN, BClabel, BCdata} !== e) begin
        miscompares++;
        $display("FAIL tag0_flush[%0d]: got ack=%b BCEN=%b label=%0d data=%0d, want ack=%b BCEN=%b label=%0d data=%0d",
                 c, ack, BCEN, BClabel, BCdata, e.ack, e.bcen, e.lbl, e.dat);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_self_mask;
    exp_t e;
    doReset;
    setUnit(1, 5'd3, 32'd77);
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0) sb.push_back('{4'b0010, 1'b1, 5'd3, 32'd77});
      else            sb.push_back('{4'b0000, 1'b0, 5'd3, 32'd77});
      tick;
      e = sb.pop_front(); vectors++;
      if ({ack, BCEN, BClabel, BCdata} !== e) begin
        miscompares++;
        $display("FAIL self_mask[%0d]: got ack=%b BCEN=%b label=%0d data=%0d, want ack=%b BCEN=%b label=%0d data=%0d",
                 c, ack, BCEN, BClabel, BCdata, e.ack, e.bcen, e.lbl, e.dat);
      end
    end
    req = '0;
  endtask

  // All four hold req: round-robin order plus busyCnt saturation.
  task automatic test_saturation;
    exp_t e;
    doReset;
    for (int i = 0; i < N; i++) setUnit(i, LW'(i + 1), DW'(200 + i));
    req = 4'b1111;
    for (int c = 0; c < 260; c++) begin
      sb.push_back('{N'(1) << (c % N), 1'b1, LW'(c % N + 1), DW'(200 + c % N)});
      tick;
      e = sb.pop_front(); vectors++;
      if ({ack, BCEN, BClabel, BCdata} !== e) begin
        miscompares++;
        $display("FAIL fairness[%0d]: got ack=%b BCEN=%b label=%0d data=%0d, want ack=%b BCEN=%b label=%0d data=%0d",
                 c, ack, BCEN, BClabel, BCdata, e.ack, e.bcen, e.lbl, e.dat);
      end
      if (c == 99 || c == 259) begin
        vectors++;
        if (busyCnt !== ((c == 99) ? 8'd100 : 8'd255)) begin
          miscompares++;
          $display("FAIL busy_sat[%0d]: got busyCnt=%0d, want %0d", c, busyCnt, (c == 99) ? 100 : 255);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_rotation;
    test_tag0_flush;
    test_self_mask;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the common data bus (CDB) that drives the broadcast inputs of every reservation station and queue: BCEN, BClabel and BCdata.
- Functional units (ALU, multiplier, load queue, …) post a completed result as a tag/value pair. The arbiter grants one requester per cycle, registers the winner onto the bus and returns a one-cycle ack.
- Sits between the functional-unit outputs and all CDB snoopers.

Parameters:
- N, 4, number of requesting functional units (2..8).
- LABEL_W, 5, tag width; tag 0 means "value ready / no producer".
- DATA_W, 32, result width.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req  in  N  per-unit broadcast request; held with label/data until ack.
- reqLabel  in  N*LABEL_W  packed tags; unit i at [i*LABEL_W +: LABEL_W].
- reqData  in  N*DATA_W  packed results; unit i at [i*DATA_W +: DATA_W].
- flush  in  1  branch/exception flush; kills arbitration this cycle.
- ack  out  N  one-hot, one-cycle grant acknowledge.
- BCEN  out  1  CDB valid.
- BClabel  out  LABEL_W  CDB tag.
- BCdata  out  DATA_W  CDB value.
- busyCnt  out  8  saturating count of cycles in which more than one request was eligible (contention statistic).

Behaviour:
- Reset (async, RST=1): ack=0, BCEN=0, BClabel=0, BCdata=0, busyCnt=0, rr pointer ptr=0. Outputs are held while RST is high.
- All outputs are registered. Latency is exactly 1 cycle from the edge that samples the request to BCEN/ack being high.
- Eligible vector: elig = req & ~ack. This masks the unit acked this cycle, so it cannot win twice while it is still dropping req.
- Pick rule: the first set bit of elig searching from index ptr upward, wrapping at N-1 -> 0.
- When a winner w exists at an edge:
  - ack <= onehot(w).
  - BCEN <= (reqLabel[w] != 0).
  - BClabel <= reqLabel[w] and BCdata <= reqData[w], both loaded even when the tag is 0.
  - ptr <= (w+1) mod N.
- When there is no winner: ack <= 0, BCEN <= 0, BClabel/BCdata hold their last values, ptr holds.
- Tag 0 request: acked, so the unit retires, but BCEN stays 0 because it is not a broadcast. ptr still advances.
- flush=1 at an edge:
  - ack <= 0, BCEN <= 0, ptr holds.
  - Requests persist and are re-arbitrated on the first edge with flush=0. Requesters are responsible for dropping squashed results.
- busyCnt increments by 1 at each edge where popcount(elig) >= 2 and flush=0, saturating at 255.
- BCEN is high for at most one cycle per grant. Back-to-back grants to different units in consecutive cycles are allowed: full bus throughput.
- A single continuous requester is served every other cycle, because of the self-mask.
- Fairness: with all N requesting continuously, each unit is granted within N consecutive grant cycles.
- req changing while not acked is legal; the sample at the edge governs.
- Reset asserted mid-broadcast: BCEN and ack drop immediately and asynchronously. The pending winner is lost and the requester keeps req high until acked after reset.

Decomposition:
- Shared package (cdb_pkg):
  - LABEL_W, DATA_W.
  - the constant NO_LABEL = 0.
  - the onehot and mod-N increment helpers.
- Sub-module rr_pick:
  - purely combinational.
  - inputs elig[N] and ptr[$clog2(N)].
  - outputs found and idx.
  - rotate / priority-encode / unrotate.
- cdb_arbiter holds only registers, masking, the statistics counter and the output mux.

Test Plan:
- Reset: assert RST asynchronously between clock edges -> all outputs read 0 immediately. Deassert, no req -> BCEN=0 and ack=0 for 3 cycles.
- Single request: req=0001, label 4, data 25 -> next cycle BCEN=1, BClabel=4, BCdata=25, ack=0001. Unit drops req -> BCEN=0 the following cycle.
- Contention: req=1111 with labels 1,2,3,4 held until each unit is acked -> BClabel sequence 1,2,3,4 on 4 consecutive cycles; ack walks 0001,0010,0100,1000; busyCnt=3.
- Rotation: after the grant to unit 2 (ptr=3), assert req=0101 -> unit 0 wins, not unit 2. A second req=0101 after that -> unit 2 wins.
- Tag 0 and flush:
  - req=0010 with label 0 -> ack=0010, BCEN=0.
  - req=0001 with label 5 and flush=1 -> no ack and BCEN=0; flush=0 -> BClabel=5 one cycle later.
- Self-mask: unit 1 holds req=0010 for 4 cycles -> ack and BCEN high on alternate cycles only, never two consecutive.
